// File: rtl/pwm_fre_multi.sv
// Multi-channel PWM generator with double-buffered period/duty/mode/polarity.
// Each channel runs edge- or center-aligned and commits new settings only at a period boundary.
module pwm_fre_multi #(
  parameter  int CH = 4,
  parameter  int W  = 20,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic          wr,
  input  logic [CW-1:0] wr_ch,
  input  logic [W-1:0]  wr_period,
  input  logic [W-1:0]  wr_duty,
  input  logic          wr_mode,
  input  logic          wr_pol,
  output logic [CH-1:0] pwm,
  output logic [CH-1:0] cyc_end,
  output logic [CH-1:0] pend
);

  typedef struct packed {
    logic [W-1:0] period;
    logic [W-1:0] duty;
    logic         mode;   // 0 = edge-aligned, 1 = center-aligned
    logic         pol;    // 1 = active-low output
  } cfg_t;

  logic wr_hit;
  assign wr_hit = wr && (32'(wr_ch) < CH);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    cfg_t         act_q, act_d, sh_q, sh_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         down_q, down_d;
    logic         pwm_q, pwm_d;
    logic         end_q, end_d;
    logic         pend_q, pend_d;
    logic         sel, raw, last;

    assign sel = wr_hit && (wr_ch == CW'(c));

    // P=0 parks the channel: never active, and every cycle counts as a period end.
    always_comb begin
      raw = (act_q.period != '0) && (cnt_q < act_q.duty);
      if (act_q.period == '0)
        last = 1'b1;
      else if (!act_q.mode)
        last = (cnt_q == act_q.period - W'(1));
      else
        last = down_q && (cnt_q == '0);
    end

    always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one
      // unassigned and infer a latch.
      act_d  = act_q;
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      down_d = down_q;
      pend_d = pend_q;
      pwm_d  = raw ^ act_q.pol;
      end_d  = last;

      if (!en[c] || last) begin
        act_d  = sh_q;
        pend_d = 1'b0;
        cnt_d  = '0;
        down_d = 1'b0;
        if (!en[c]) begin
          pwm_d = act_q.pol;
          end_d = 1'b0;
        end
      end else if (!act_q.mode) begin
        cnt_d = cnt_q + W'(1);
      end else if (!down_q) begin
        // The top count is held for a second cycle while the direction flips.
        if (cnt_q == act_q.period - W'(1))
          down_d = 1'b1;
        else
          cnt_d = cnt_q + W'(1);
      end else begin
        cnt_d = cnt_q - W'(1);
      end

      // A write on a commit edge lands after the commit took the old shadow, so it stays pending.
      if (sel) begin
        sh_d   = '{period: wr_period, duty: wr_duty, mode: wr_mode, pol: wr_pol};
        pend_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register samples the
      // pre-edge values, regardless of statement order.
      if (rst) begin
        act_q  <= '0;
        sh_q   <= '0;
        cnt_q  <= '0;
        down_q <= 1'b0;
        pwm_q  <= 1'b0;
        end_q  <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        act_q  <= act_d;
        sh_q   <= sh_d;
        cnt_q  <= cnt_d;
        down_q <= down_d;
        pwm_q  <= pwm_d;
        end_q  <= end_d;
        pend_q <= pend_d;
      end
    end

    assign pwm[c]     = pwm_q;
    assign cyc_end[c] = end_q;
    assign pend[c]    = pend_q;
  end

endmodule

// File: tb/tb_pwm_fre_multi.sv
// Directed bench for pwm_fre_multi with three channels, so wr_ch can address one past the last channel.
module tb_pwm_fre_multi;
  localparam int CH = 3;
  localparam int W  = 20;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic          wr;
  logic [CW-1:0] wr_ch;
  logic [W-1:0]  wr_period;
  logic [W-1:0]  wr_duty;
  logic          wr_mode;
  logic          wr_pol;
  logic [CH-1:0] pwm;
  logic [CH-1:0] cyc_end;
  logic [CH-1:0] pend;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_fre_multi #(.CH(CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wr        (wr),
    .wr_ch     (wr_ch),
    .wr_period (wr_period),
    .wr_duty   (wr_duty),
    .wr_mode   (wr_mode),
    .wr_pol    (wr_pol),
    .pwm       (pwm),
    .cyc_end   (cyc_end),
    .pend      (pend)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too, half a cycle after the rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_wr(input int ch, input int p, input int d, input logic m, input logic pol);
    wr        = 1'b1;
    wr_ch     = CW'(ch);
    wr_period = W'(p);
    wr_duty   = W'(d);
    wr_mode   = m;
    wr_pol    = pol;
  endtask

  // Disabled channel: first edge writes the shadow, second edge commits it.
  task automatic load(input int ch, input int p, input int d, input logic m, input logic pol);
    en[ch] = 1'b0;
    set_wr(ch, p, d, m, pol);
    step();
    wr = 1'b0;
    check("load_pend_set", 32'(pend[ch]), 32'd1);
    step();
    check("load_pend_clr", 32'(pend[ch]), 32'd0);
  endtask

  initial begin
    int pos;
    rst = 1'b1;
    en  = '1;
    set_wr(0, 10, 3, 1'b0, 1'b1);
    step();
    step();
    check("rst_pwm",  32'(pwm),     32'd0);
    check("rst_end",  32'(cyc_end), 32'd0);
    check("rst_pend", 32'(pend),    32'd0);
    rst = 1'b0;
    wr  = 1'b0;
    en  = '0;

    // Edge-aligned P=10 D=3: 3 high, 7 low, cyc_end in the last low cycle.
    load(0, 10, 3, 1'b0, 1'b0);
    en[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("edge_pwm", 32'(pwm[0]),     32'((i % 10) < 3));
      check("edge_end", 32'(cyc_end[0]), 32'((i % 10) == 9));
    end

    // Shadow write of D=7 while cnt=4; current period keeps D=3.
    for (int i = 0; i < 10; i++) begin
      if (i == 4) set_wr(0, 10, 7, 1'b0, 1'b0);
      step();
      wr = 1'b0;
      check("shadow_old_pwm", 32'(pwm[0]),     32'(i < 3));
      check("shadow_old_end", 32'(cyc_end[0]), 32'(i == 9));
      if (i >= 4) check("shadow_pend", 32'(pend[0]), 32'(i != 9));
    end
    for (int i = 0; i < 10; i++) begin
      step();
      check("shadow_new_pwm", 32'(pwm[0]),     32'(i < 7));
      check("shadow_new_end", 32'(cyc_end[0]), 32'(i == 9));
    end
    en[0] = 1'b0;

    // Center-aligned P=8 D=3: period 16, 6 high cycles straddling the wrap.
    load(1, 8, 3, 1'b1, 1'b0);
    en[1] = 1'b1;
    for (int j = 0; j < 32; j++) begin
      pos = j % 16;
      step();
      check("center_pwm", 32'(pwm[1]),     32'((pos < 3) || (pos >= 13)));
      check("center_end", 32'(cyc_end[1]), 32'(pos == 15));
    end
    en[1] = 1'b0;

    load(2, 10, 0, 1'b0, 1'b0);
    en[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("d0_pwm", 32'(pwm[2]),     32'd0);
      check("d0_end", 32'(cyc_end[2]), 32'((i % 10) == 9));
    end

    load(2, 10, 12, 1'b0, 1'b0);
    en[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("dbig_pwm", 32'(pwm[2]), 32'd1);
    end

    load(2, 0, 5, 1'b0, 1'b1);
    en[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("p0_pwm", 32'(pwm[2]),     32'd1);
      check("p0_end", 32'(cyc_end[2]), 32'd1);
    end

    // wr_ch == CH must not touch any shadow or pend bit.
    set_wr(3, 10, 3, 1'b0, 1'b0);
    step();
    wr = 1'b0;
    check("oob_pend", 32'(pend),   32'd0);
    check("oob_pwm",  32'(pwm[2]), 32'd1);
    en[2] = 1'b0;
    step();
    check("oob_dis_pwm", 32'(pwm[2]),     32'd1);
    check("oob_dis_end", 32'(cyc_end[2]), 32'd0);
    en[2] = 1'b1;
    step();
    check("oob_re_pwm", 32'(pwm[2]),     32'd1);
    check("oob_re_end", 32'(cyc_end[2]), 32'd1);
    en[2] = 1'b0;

    // Active-low P=10 D=3, then disable and re-enable mid-period.
    load(0, 10, 3, 1'b0, 1'b1);
    en[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check("pol_pwm", 32'(pwm[0]), 32'(!((i % 10) < 3)));
    end
    en[0] = 1'b0;
    step();
    check("dis_pwm", 32'(pwm[0]),     32'd1);
    check("dis_end", 32'(cyc_end[0]), 32'd0);
    step();
    check("dis_pwm2", 32'(pwm[0]), 32'd1);
    en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("reen_pwm", 32'(pwm[0]), 32'(i == 3));
    end

    // Synchronous reset while active with a pending write.
    load(0, 10, 3, 1'b0, 1'b0);
    en[0] = 1'b1;
    step();
    check("pre_rst_pwm", 32'(pwm[0]), 32'd1);
    set_wr(0, 10, 5, 1'b0, 1'b0);
    step();
    wr = 1'b0;
    check("pre_rst_pend", 32'(pend[0]), 32'd1);
    check("pre_rst_pwm2", 32'(pwm[0]),  32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_pwm",  32'(pwm),     32'd0);
    check("mid_rst_end",  32'(cyc_end), 32'd0);
    check("mid_rst_pend", 32'(pend),    32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_pwm",  32'(pwm[0]),  32'd0);
      check("post_rst_pend", 32'(pend[0]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
